// File: rtl/nn_pkg.sv
// Shared types for the dense-layer inference path: activation selection,
// sequencer state encoding and the common counter width.
package nn_pkg;

  typedef enum logic {
    RELU,
    SIGMOID
  } activation_type;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    OUTPUT,
    ERROR
  } seq_state_t;

  localparam int COUNT_WIDTH = 16;

endpackage

// File: rtl/layer_watchdog.sv
// Per-layer cycle timer: counts cycles since a layer's start pulse and flags
// when layer_done may be trusted (holdoff) and when the layer has hung.
module layer_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DONE_HOLDOFF   = 2,
  localparam int TW            = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  output logic holdoff_met,
  output logic expired
);

  logic [TW-1:0] count;

  // Timer freezes once expired so it can never wrap back under the limit.
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TW'(1);
    end
  end

  assign holdoff_met = (count >= TW'(DONE_HOLDOFF));
  assign expired     = (count >= TW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/network_sequencer.sv
// Steps one inference through a chain of dense layers: start pulse per layer,
// wait for its qualified done, present the result, and trap hung layers.
module network_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DONE_HOLDOFF   = 2,
  localparam int LW            = $clog2(NUM_LAYERS) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NUM_LAYERS-1:0]  layer_start,
  input  logic [NUM_LAYERS-1:0]  layer_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [LW-1:0]          current_layer,
  output logic                   error,
  input  logic                   clear_error,
  output logic [COUNT_WIDTH-1:0] infer_cycles
);

  seq_state_t             state_q, state_d;
  logic [LW-1:0]          layer_q;
  logic                   armed_q;
  logic                   error_q;
  logic [COUNT_WIDTH-1:0] infer_cnt_q;
  logic [COUNT_WIDTH-1:0] infer_cycles_q;
  logic                   accept;
  logic                   done_sel;
  logic                   done_qual;
  logic                   last_layer;
  logic                   holdoff_met;
  logic                   expired;
  logic                   wd_clear;
  logic                   wd_enable;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign accept     = in_valid && in_ready;
  assign last_layer = (layer_q == LW'(NUM_LAYERS - 1));
  assign done_qual  = done_sel && holdoff_met;
  assign wd_clear   = reset || (state_d == START);
  assign wd_enable  = (state_q == START) || (state_q == WAIT);

  always_comb begin
    done_sel = 1'b0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (layer_q == LW'(k)) done_sel = layer_done[k];
    end
  end

  layer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .DONE_HOLDOFF  (DONE_HOLDOFF)
  ) u_watchdog (
    .clock      (clock),
    .clear      (wd_clear),
    .enable     (wd_enable),
    .holdoff_met(holdoff_met),
    .expired    (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      layer_q        <= '0;
      armed_q        <= 1'b0;
      error_q        <= 1'b0;
      infer_cnt_q    <= '0;
      infer_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (accept) begin
        layer_q <= '0;
      end else if (state_q == WAIT && state_d == START) begin
        layer_q <= layer_q + LW'(1);
      end
      if (state_q == WAIT && state_d == ERROR) begin
        error_q <= 1'b1;
      end else if (state_q == ERROR && clear_error) begin
        error_q <= 1'b0;
      end
      // Count includes the accept cycle, so OUTPUT entry records cnt+1.
      if (accept) begin
        infer_cnt_q <= COUNT_WIDTH'(1);
      end else if (wd_enable) begin
        infer_cnt_q <= sat_inc(infer_cnt_q);
      end
      if (state_q == WAIT && state_d == OUTPUT) begin
        infer_cycles_q <= sat_inc(infer_cnt_q);
      end
    end
  end

  // A qualified done takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   state_d = WAIT;
      WAIT: begin
        if (done_qual)    state_d = last_layer ? OUTPUT : START;
        else if (expired) state_d = ERROR;
      end
      OUTPUT:  if (out_ready) state_d = IDLE;
      ERROR:   if (clear_error) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready      = armed_q && (state_q == IDLE);
    out_valid     = (state_q == OUTPUT);
    busy          = (state_q != IDLE);
    current_layer = (state_q == IDLE) ? '0 : layer_q;
    error         = error_q;
    infer_cycles  = infer_cycles_q;
    layer_start   = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      layer_start[k] = (state_q == START) && (layer_q == LW'(k));
    end
  end

endmodule
